// File: rtl/pipelined_alu_if.sv
// Operand/result bus for pipelined_alu: an operand stream in and a result stream out.
// Both streams use valid/ready: a beat transfers on the rising edge where valid && ready;
// the sender holds its payload stable while valid is high and ready is low.
interface pipelined_alu_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op_code;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;

    modport slave (
        input  in_valid, a, b, op_code, out_ready,
        output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
    );

    modport master (
        output in_valid, a, b, op_code, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
    );
endinterface

// File: rtl/pipelined_alu.sv
// Two-stage ALU: S1 captures operands, S2 computes and holds result/flags until consumed.
// Eight ops, Z/N/C/V flags, full back-pressure at one op per cycle.
module pipelined_alu #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    pipelined_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_SLT = 3'b111
    } op_e;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;  // {z, n, c, v}

    logic             s2_ready;
    logic             accept;
    logic             s1_xfer;
    logic             emit;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    // in_ready deliberately does not look at in_valid, so producers may wait on it.
    assign s2_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && bus.in_ready;
    assign s1_xfer  = s1_valid_q && s2_ready;
    assign emit     = out_valid_q && bus.out_ready;

    assign bus.in_ready  = !s1_valid_q || s2_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flag_z    = flags_q[3];
    assign bus.flag_n    = flags_q[2];
    assign bus.flag_c    = flags_q[1];
    assign bus.flag_v    = flags_q[0];

    // The top bit of the WIDTH+1 subtraction is the unsigned borrow.
    assign sum   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign diff  = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    assign shamt = s1_b_q[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_e'(s1_op_q))
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                          (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                          (diff[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_AND: alu_res = s1_a_q & s1_b_q;
            OP_OR:  alu_res = s1_a_q | s1_b_q;
            OP_XOR: alu_res = s1_a_q ^ s1_b_q;
            OP_SLL: alu_res = s1_a_q << shamt;
            OP_SRL: alu_res = s1_a_q >> shamt;
            OP_SLT: alu_res[0] = $signed(s1_a_q) < $signed(s1_b_q);
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = bus.a;
            s1_b_d     = bus.b;
            s1_op_d    = bus.op_code;
        end else if (s1_xfer) begin
            s1_valid_d = 1'b0;
        end

        // S2 only reloads on a transfer, so a stalled result never moves.
        if (s1_xfer) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            flags_d     = {alu_res == '0, alu_res[WIDTH-1], alu_c, alu_v};
        end else if (emit) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end
endmodule

// File: tb/tb_pipelined_alu.sv
// Bench for pipelined_alu (WIDTH=8): directed vectors, stall/ordering, reset mid-stream,
// and a randomised handshake stream scored against an integer reference model.
module tb_pipelined_alu;
    localparam int WIDTH = 8;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } stim_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [11:0] exp_q[$];  // {z, n, c, v, result}
    stim_t       stim_q[$];

    pipelined_alu_if #(.WIDTH(WIDTH)) bus ();

    pipelined_alu #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] observed();
        return {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.result};
    endfunction

    // Reference model works in plain integers rather than bit-level carry tricks.
    function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, r;
        bit c, v;
        logic [7:0] res;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        c = 1'b0; v = 1'b0; res = '0; r = 0;
        case (op)
            3'd0: begin r = ua + ub; res = r[7:0]; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            3'd1: begin r = ua - ub; res = r[7:0]; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = a << b[2:0];
            3'd6: res = a >> b[2:0];
            default: res = (sa < sb) ? 8'd1 : 8'd0;
        endcase
        return {res == 8'd0, res[7], c, v, res};
    endfunction

    // Called at #1 after a rising edge with an idle pipeline.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic [3:0] ef);
        bus.out_ready = 1'b1;
        bus.op_code   = op;
        bus.a         = a;
        bus.b         = b;
        bus.in_valid  = 1'b1;
        check({tag, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        check({tag, "_early"}, bus.out_valid, 0);
        @(posedge clk); #1;
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_result"}, bus.result, er);
        check({tag, "_flags_zncv"}, {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, ef);
        @(posedge clk); #1;
        check({tag, "_drained"}, bus.out_valid, 0);
    endtask

    // Streams stim_q through the DUT, scoring every emitted beat in order.
    task automatic run_stream(input string tag, input int n_ops, input bit rand_valid,
                              input bit rand_ready, input int budget);
        int          sent;
        int          cyc;
        bit          acc_now;
        bit          prev_hold;
        logic [11:0] prev_snap;
        logic [11:0] exp_v;
        sent = 0; cyc = 0; prev_hold = 1'b0; prev_snap = '0;
        while ((sent < n_ops || exp_q.size() != 0) && cyc < budget) begin
            if (!bus.in_valid) begin
                if (sent < n_ops && (!rand_valid || $urandom_range(0, 3) != 0)) begin
                    bus.op_code  = stim_q[sent].op;
                    bus.a        = stim_q[sent].a;
                    bus.b        = stim_q[sent].b;
                    bus.in_valid = 1'b1;
                end else begin
                    bus.a       = 8'($urandom);
                    bus.b       = 8'($urandom);
                    bus.op_code = 3'($urandom);
                end
            end
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (prev_hold) check({tag, "_stable"}, observed(), prev_snap);
            if (bus.out_valid && bus.out_ready) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL %s_extra observed=%0h expected=none", tag, observed());
                end
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    check({tag, "_beat"}, observed(), exp_v);
                end
            end
            acc_now = bus.in_valid && bus.in_ready;
            if (acc_now) begin
                exp_q.push_back(model(bus.op_code, bus.a, bus.b));
                sent++;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_snap = observed();
            @(posedge clk); #1;
            if (acc_now) bus.in_valid = 1'b0;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check({tag, "_all_sent"}, sent, n_ops);
        check({tag, "_drain_left"}, exp_q.size(), 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.op_code  = '0;

        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_flags", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", bus.in_ready, 1);

        do_op("add_ff_01", 3'b000, 8'hFF, 8'h01, 8'h00, 4'b1010);
        do_op("sub_80_01", 3'b001, 8'h80, 8'h01, 8'h7F, 4'b0001);
        do_op("sub_01_02", 3'b001, 8'h01, 8'h02, 8'hFF, 4'b0110);
        do_op("sub_05_05", 3'b001, 8'h05, 8'h05, 8'h00, 4'b1000);
        do_op("add_7f_01", 3'b000, 8'h7F, 8'h01, 8'h80, 4'b0101);
        do_op("and_f0_3c", 3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000);
        do_op("or_0f_f0",  3'b011, 8'h0F, 8'hF0, 8'hFF, 4'b0100);
        do_op("xor_aa_aa", 3'b100, 8'hAA, 8'hAA, 8'h00, 4'b1000);
        do_op("sll_81_09", 3'b101, 8'h81, 8'h09, 8'h02, 4'b0000);
        do_op("srl_80_07", 3'b110, 8'h80, 8'h07, 8'h01, 4'b0000);
        do_op("slt_fe_01", 3'b111, 8'hFE, 8'h01, 8'h01, 4'b0000);
        do_op("slt_01_fe", 3'b111, 8'h01, 8'hFE, 8'h00, 4'b1000);

        // Six back-to-back ops with the consumer stalled at first.
        exp_q.delete();
        stim_q.delete();
        bus.out_ready = 1'b0;
        bus.op_code = 3'b000; bus.a = 8'h10; bus.b = 8'h20; bus.in_valid = 1'b1;
        check("stall_rdy_op0", bus.in_ready, 1);
        exp_q.push_back(model(3'b000, 8'h10, 8'h20));
        @(posedge clk); #1;
        bus.op_code = 3'b001; bus.a = 8'h50; bus.b = 8'h60;
        check("stall_rdy_op1", bus.in_ready, 1);
        exp_q.push_back(model(3'b001, 8'h50, 8'h60));
        @(posedge clk); #1;
        stim_q.push_back('{op: 3'b100, a: 8'h5A, b: 8'hFF});
        stim_q.push_back('{op: 3'b101, a: 8'h01, b: 8'h07});
        stim_q.push_back('{op: 3'b111, a: 8'h80, b: 8'h7F});
        stim_q.push_back('{op: 3'b000, a: 8'h80, b: 8'h80});
        bus.op_code = stim_q[0].op; bus.a = stim_q[0].a; bus.b = stim_q[0].b;
        check("stall_full_in_ready", bus.in_ready, 0);
        check("stall_out_valid", bus.out_valid, 1);
        check("stall_head", observed(), exp_q[0]);
        repeat (3) begin
            @(posedge clk); #1;
            check("stall_hold_in_ready", bus.in_ready, 0);
            check("stall_hold_head", observed(), exp_q[0]);
        end
        run_stream("stall", 4, 1'b0, 1'b0, 50);

        // Randomised valid/ready traffic.
        stim_q.delete();
        exp_q.delete();
        for (int i = 0; i < 2000; i++) begin
            stim_q.push_back('{op: 3'($urandom), a: 8'($urandom), b: 8'($urandom)});
        end
        run_stream("rand", 2000, 1'b1, 1'b1, 20000);

        // Reset pulse with both stages full.
        exp_q.delete();
        bus.out_ready = 1'b0;
        bus.op_code = 3'b000; bus.a = 8'h11; bus.b = 8'h22; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.op_code = 3'b010; bus.a = 8'hF3; bus.b = 8'h3F;
        @(posedge clk); #1;
        check("prerst_out_valid", bus.out_valid, 1);
        check("prerst_in_ready", bus.in_ready, 0);
        #2;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_result", bus.result, 0);
        check("midrst_flags", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        check("relrst_in_ready", bus.in_ready, 1);
        repeat (4) begin
            @(posedge clk); #1;
            check("relrst_no_stale", bus.out_valid, 0);
        end
        do_op("add_03_04", 3'b000, 8'h03, 8'h04, 8'h07, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
